// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the fifo_wr_arb round-robin write arbiter.
package fifo_wr_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_e;

  // Explicit modulo wrap so non-power-of-two requester counts work.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Round-robin pick: first set request at or after rr_ptr, wrapping to the lowest set request.
module fifo_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               found,
  output logic [PTR_W-1:0]   idx
);

  logic [NUM_REQ-1:0] masked;
  logic [PTR_W-1:0]   idx_lo;
  logic [PTR_W-1:0]   idx_hi;

  always_comb begin
    masked = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      masked[i] = req[i] && (i >= int'(rr_ptr));
    end
  end

  // Scan high to low so the lowest set index wins in each vector.
  always_comb begin
    idx_lo = '0;
    idx_hi = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i])    idx_lo = PTR_W'(i);
      if (masked[i]) idx_hi = PTR_W'(i);
    end
  end

  assign found = |req;
  assign idx   = (|masked) ? idx_hi : idx_lo;

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing one FIFO write port; registered write stage.
// Optional macro FIFO_WR_ARB_PRIO_EN: requester 0 wins in IDLE and preempts other owners.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_pfull,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_wr_en,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e            state;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      owner;
  logic [CNT_W-1:0]      beat_cnt;

  logic                  pick_found;
  logic [PTR_W-1:0]      pick_idx;
  logic [PTR_W-1:0]      next_owner;
  logic                  granted;
  logic                  room;
  logic                  owner_valid;
  logic                  accept;
  logic                  last_beat;
  logic                  drained;
  logic                  preempt;
  logic                  leave;
  logic [DATA_WIDTH-1:0] owner_data;

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  assign granted     = (state == ARB_GRANT);
  assign room        = !fifo_full && !fifo_pfull;
  assign owner_valid = req_valid[owner];
  assign owner_data  = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
  assign accept      = granted && owner_valid && room;
  assign last_beat   = (beat_cnt == CNT_W'(MAX_BURST - 1));
  // Drain only counts when not throttled, so a throttled owner keeps its grant.
  assign drained     = granted && room && !owner_valid;

`ifdef FIFO_WR_ARB_PRIO_EN
  assign preempt    = granted && room && (owner != '0) && req_valid[0];
  assign next_owner = req_valid[0] ? '0 : pick_idx;
`else
  assign preempt    = 1'b0;
  assign next_owner = pick_idx;
`endif

  assign leave    = drained || (accept && last_beat) || preempt;
  assign busy     = granted;
  assign grant_id = owner;

  always_comb begin
    req_ready = '0;
    if (granted) req_ready[owner] = room;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      beat_cnt   <= '0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
    end else begin
      fifo_wr_en <= accept;
      if (accept) fifo_din <= owner_data;
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            owner    <= next_owner;
            beat_cnt <= '0;
            state    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (accept) beat_cnt <= beat_cnt + CNT_W'(1);
          if (leave) begin
            state  <= ARB_IDLE;
            rr_ptr <= PTR_W'(rr_next(int'(owner), NUM_REQ));
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(fifo_wr_en && fifo_full))
        else $error("fifo_wr_arb: write issued into a full FIFO");
      assert ($onehot0(req_ready))
        else $error("fifo_wr_arb: more than one req_ready asserted");
    end
  end
`endif

endmodule
